safe_lock_fsm: RTL and testbench
================================

// Module: safe_lock_fsm
// PURPOSE
//  Master control FSM of the digital safe. Consumes debounced keypad events and the
//  emergency request, checks the entered code, and drives the 4-bit state bus that the
//  LED/piezo feedback block decodes. All timing is counted on the 1 kHz system tick.
// PARAMETERS
//  PW_LEN          4        digits per code (1..8)
//  DEFAULT_PW      32'h1234 reset code, one BCD nibble per digit, MSB nibble = first digit
//  MAX_FAIL        3        consecutive failures that trigger LOCKOUT (1..7)
//  SUCCESS_MS      3000     SUCCESS hold time, clk_1khz cycles
//  FAIL_MS         1000     FAIL hold time
//  LOCKOUT_MS      10000    LOCKOUT hold time
//  ENTRY_TIMEOUT_MS 5000    idle-key timeout while entering digits
// PORTS
//  clk_1khz      in   1   system clock, 1 kHz
//  rst           in   1   asynchronous, active-high reset
//  key_valid     in   1   one-cycle pulse: key_code is valid
//  key_code      in   4   0-9 digit, 4'hA '*' clear, 4'hB '#' enter, others ignored
//  emergency_req in   1   level; high = emergency override
//  state         out  4   state code to feedback block (registered)
//  unlock        out  1   solenoid drive, high only in SUCCESS
//  digit_count   out  4   digits currently buffered
//  fail_count    out  3   consecutive failures
// BEHAVIOUR
//  Codes: IDLE 0000, ENTRY 0001, CHECK 0010, SET_ENTRY 0100, SUCCESS 0111, FAIL 1000,
//   LOCKOUT 1001, EMERGENCY 1010. Reset: state=IDLE, unlock=0, digit_count=0,
//   fail_count=0, digit buffer cleared, stored code=DEFAULT_PW, timer=0.
//  IDLE: digit -> ENTRY, digit stored, count=1. '*'/'#' ignored.
//  ENTRY: digit appended while count<PW_LEN; extra digits dropped (count saturates).
//   '*' -> IDLE, buffer cleared. '#' -> CHECK. No key for ENTRY_TIMEOUT_MS -> IDLE, cleared.
//   Each accepted key reloads the timeout.
//  CHECK (exactly 1 cycle): match iff count==PW_LEN and all digits equal. Match ->
//   SUCCESS, fail_count=0. Mismatch: fail_count+1; if new value==MAX_FAIL -> LOCKOUT,
//   else -> FAIL. Buffer cleared on leaving CHECK.
//  SUCCESS/FAIL/LOCKOUT: hold for *_MS cycles, then IDLE; key events ignored (except
//   PW_CHANGE_EN). LOCKOUT exit clears fail_count. unlock = (state==SUCCESS), registered
//   with state so both change on the same edge.
//  EMERGENCY: emergency_req high in any state -> EMERGENCY next edge; highest priority,
//   a same-cycle key is dropped and running timers are abandoned. Stays while high; on
//   deassert -> IDLE, buffer cleared, fail_count preserved (LOCKOUT is not bypassed by
//   counter reset).
//  Timer: one down-counter, 14 bits, loaded on entry to each timed state, expire when 0.
//   Key and expiry in the same ENTRY cycle: key wins.
//  rst mid-operation: immediate return to reset values, incl. stored code=DEFAULT_PW.
// CONFIGURATION
//  SAFE_PW_CHANGE_EN defined: in SUCCESS, '*' -> SET_ENTRY (unlock drops to 0). SET_ENTRY
//   collects digits like ENTRY; '#' with count==PW_LEN stores buffer as new code -> IDLE;
//   '#' with short count, '*', or timeout -> IDLE, code unchanged.
//  Not defined: code fixed at DEFAULT_PW, SET_ENTRY unreachable, '*' ignored in SUCCESS.
// STRUCTURE
//  safe_pkg (shared include): state codes, key codes. Also consumed by feedback block.
//  Sub-module ms_timer: loadable 14-bit down-counter with an expired flag.
//  Digit buffer: shift register, PW_LEN x 4 bits.
// TESTING
//  1 Keys 1,2,3,4,# -> CHECK one cycle, SUCCESS 3000 cycles, unlock=1, then IDLE.
//  2 Keys 1,2,3,5,# three times -> FAIL, FAIL, then LOCKOUT for 10000 cycles; fail_count
//    reads 1,2,3; LOCKOUT exit clears it to 0.
//  3 Keys 1,2,3,4,5,# -> extra digit dropped, digit_count=4, SUCCESS; keys 1,2,# -> FAIL.
//  4 Key 1, then 5000 cycles with no key -> IDLE, digit_count=0; key at cycle 4999 -> timeout restarts.
//  5 emergency_req high mid-ENTRY and mid-LOCKOUT -> EMERGENCY next edge; release -> IDLE,
//    fail_count unchanged.
//  6 (SAFE_PW_CHANGE_EN) SUCCESS, *,9,8,7,6,# -> IDLE; 9,8,7,6,# -> SUCCESS; 1,2,3,4,# -> FAIL.

Source files
------------

// File: rtl/safe_pkg.sv
// -----------------------------------------------------------------------------
// safe_pkg
// Shared definitions for the digital safe: the 4-bit state codes that appear on
// the state bus (also decoded by the LED/piezo feedback block), the special
// keypad codes, the timer width and a digit-classification helper.
// No ports.
// -----------------------------------------------------------------------------
package safe_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0000,
    ST_ENTRY     = 4'b0001,
    ST_CHECK     = 4'b0010,
    ST_SET_ENTRY = 4'b0100,
    ST_SUCCESS   = 4'b0111,
    ST_FAIL      = 4'b1000,
    ST_LOCKOUT   = 4'b1001,
    ST_EMERGENCY = 4'b1010
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;  // '*'
  localparam logic [3:0] KEY_ENTER = 4'hB;  // '#'

  localparam int TIMER_W = 14;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/safe_lock_fsm_if.sv
// -----------------------------------------------------------------------------
// safe_lock_fsm_if
// Keypad/emergency inputs and status outputs of the safe controller.
//   key_valid     : one-cycle pulse, key_code valid
//   key_code      : 0-9 digit, A '*', B '#', others ignored
//   emergency_req : level, emergency override
//   state         : registered state code
//   unlock        : solenoid drive
//   digit_count   : digits buffered
//   fail_count    : consecutive failures
// master = keypad / system side, slave = safe_lock_fsm.
// -----------------------------------------------------------------------------
interface safe_lock_fsm_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       emergency_req;
  logic [3:0] state;
  logic       unlock;
  logic [3:0] digit_count;
  logic [2:0] fail_count;

  modport master (
    output key_valid, key_code, emergency_req,
    input  state, unlock, digit_count, fail_count
  );

  modport slave (
    input  key_valid, key_code, emergency_req,
    output state, unlock, digit_count, fail_count
  );
endinterface

// File: rtl/safe_lock_fsm_ms_timer.sv
// -----------------------------------------------------------------------------
// ms_timer
// Loadable down-counter on the 1 kHz tick. Counts down to zero and stops there;
// expired is high while the count is zero.
//   clk_1khz, rst : clock, async active-high reset
//   load, load_val: reload the counter (wins over counting)
//   expired       : count == 0
// -----------------------------------------------------------------------------
module ms_timer
  import safe_pkg::*;
(
  input  logic               clk_1khz,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/safe_lock_fsm.sv
// -----------------------------------------------------------------------------
// safe_lock_fsm
// Master control FSM of the digital safe: buffers keypad digits, checks the
// entered code, times SUCCESS/FAIL/LOCKOUT holds and the entry idle timeout,
// and handles the emergency override. All outputs are registered.
//   clk_1khz : 1 kHz system clock
//   rst      : asynchronous active-high reset
//   bus      : safe_lock_fsm_if.slave (keys, emergency, state/unlock/counts)
// Build option: define SAFE_PW_CHANGE_EN to allow changing the code from
// SUCCESS via '*' (SET_ENTRY). Without it the code is fixed at DEFAULT_PW.
// -----------------------------------------------------------------------------
module safe_lock_fsm
  import safe_pkg::*;
#(
  parameter int          PW_LEN           = 4,
  parameter logic [31:0] DEFAULT_PW       = 32'h1234,
  parameter int          MAX_FAIL         = 3,
  parameter int          SUCCESS_MS       = 3000,
  parameter int          FAIL_MS          = 1000,
  parameter int          LOCKOUT_MS       = 10000,
  parameter int          ENTRY_TIMEOUT_MS = 5000
) (
  input logic           clk_1khz,
  input logic           rst,
  safe_lock_fsm_if.slave bus
);

  localparam int               BUF_W    = PW_LEN * 4;
  localparam logic [BUF_W-1:0] RESET_PW = DEFAULT_PW[BUF_W-1:0];

  // The timer is loaded on the entry edge, so a hold of N cycles loads N-1.
  localparam logic [TIMER_W-1:0] LD_SUCCESS = TIMER_W'(SUCCESS_MS - 1);
  localparam logic [TIMER_W-1:0] LD_FAIL    = TIMER_W'(FAIL_MS - 1);
  localparam logic [TIMER_W-1:0] LD_LOCKOUT = TIMER_W'(LOCKOUT_MS - 1);
  localparam logic [TIMER_W-1:0] LD_ENTRY   = TIMER_W'(ENTRY_TIMEOUT_MS - 1);

  state_e           state_q, state_d;
  logic             unlock_q, unlock_d;
  logic [3:0]       digit_count_q, digit_count_d;
  logic [2:0]       fail_count_q, fail_count_d;
  logic [BUF_W-1:0] digits_q, digits_d;
  logic [BUF_W-1:0] pw_code;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expired;

  logic       key_digit, key_clear, key_enter, pw_change_req;
  logic [2:0] fail_inc;
  logic       pw_match;

`ifdef SAFE_PW_CHANGE_EN
  logic [BUF_W-1:0] pw_q, pw_d;
  assign pw_code       = pw_q;
  assign pw_change_req = key_clear;
`else
  assign pw_code       = RESET_PW;
  assign pw_change_req = 1'b0;
`endif

  ms_timer u_timer (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign key_digit = bus.key_valid && is_digit(bus.key_code);
  assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);

  // Saturating increment: a count already at or above MAX_FAIL (left over
  // from a lockout interrupted by EMERGENCY) locks out again on the next miss.
  assign fail_inc = (fail_count_q == 3'd7) ? 3'd7 : fail_count_q + 3'd1;
  assign pw_match = (digit_count_q == 4'(PW_LEN)) && (digits_q == pw_code);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    digits_d      = digits_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    tmr_load      = 1'b0;
    tmr_val       = LD_ENTRY;
`ifdef SAFE_PW_CHANGE_EN
    pw_d          = pw_q;
`endif

    if (bus.emergency_req) begin
      // Overrides everything; a same-cycle key is dropped, timers abandoned.
      state_d = ST_EMERGENCY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_digit) begin
            state_d       = ST_ENTRY;
            digits_d      = BUF_W'(bus.key_code);
            digit_count_d = 4'd1;
            tmr_load      = 1'b1;
          end
        end

        ST_ENTRY, ST_SET_ENTRY: begin
          // A key is checked before expiry, so a key on the expiry cycle wins.
          if (key_digit) begin
            if (digit_count_q < 4'(PW_LEN)) begin
              digits_d      = (digits_q << 4) | BUF_W'(bus.key_code);
              digit_count_d = digit_count_q + 4'd1;
            end
            tmr_load = 1'b1;
          end else if (key_clear) begin
            state_d       = ST_IDLE;
            digits_d      = '0;
            digit_count_d = '0;
          end else if (key_enter) begin
            if (state_q == ST_ENTRY) begin
              state_d = ST_CHECK;
            end else begin
`ifdef SAFE_PW_CHANGE_EN
              if (digit_count_q == 4'(PW_LEN)) pw_d = digits_q;
`endif
              state_d       = ST_IDLE;
              digits_d      = '0;
              digit_count_d = '0;
            end
          end else if (tmr_expired) begin
            state_d       = ST_IDLE;
            digits_d      = '0;
            digit_count_d = '0;
          end
        end

        ST_CHECK: begin
          digits_d      = '0;
          digit_count_d = '0;
          tmr_load      = 1'b1;
          if (pw_match) begin
            state_d      = ST_SUCCESS;
            fail_count_d = '0;
            tmr_val      = LD_SUCCESS;
          end else begin
            fail_count_d = fail_inc;
            if (fail_inc >= 3'(MAX_FAIL)) begin
              state_d = ST_LOCKOUT;
              tmr_val = LD_LOCKOUT;
            end else begin
              state_d = ST_FAIL;
              tmr_val = LD_FAIL;
            end
          end
        end

        ST_SUCCESS: begin
          if (pw_change_req) begin
            state_d  = ST_SET_ENTRY;
            tmr_load = 1'b1;
          end else if (tmr_expired) begin
            state_d = ST_IDLE;
          end
        end

        ST_FAIL: begin
          if (tmr_expired) state_d = ST_IDLE;
        end

        ST_LOCKOUT: begin
          if (tmr_expired) begin
            state_d      = ST_IDLE;
            fail_count_d = '0;
          end
        end

        ST_EMERGENCY: begin
          // Release: failure count is kept so lockout cannot be bypassed.
          state_d       = ST_IDLE;
          digits_d      = '0;
          digit_count_d = '0;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    unlock_d = (state_d == ST_SUCCESS);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      unlock_q      <= 1'b0;
      digit_count_q <= '0;
      fail_count_q  <= '0;
      digits_q      <= '0;
`ifdef SAFE_PW_CHANGE_EN
      pw_q          <= RESET_PW;
`endif
    end else begin
      state_q       <= state_d;
      unlock_q      <= unlock_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      digits_q      <= digits_d;
`ifdef SAFE_PW_CHANGE_EN
      pw_q          <= pw_d;
`endif
    end
  end

  assign bus.state       = state_q;
  assign bus.unlock      = unlock_q;
  assign bus.digit_count = digit_count_q;
  assign bus.fail_count  = fail_count_q;

endmodule

// File: tb/tb_safe_lock_fsm.sv
module tb_safe_lock_fsm;

  localparam int          PW_LEN           = 4;
  localparam logic [31:0] DEFAULT_PW       = 32'h1234;
  localparam int          MAX_FAIL         = 3;
  localparam int          SUCCESS_MS       = 3000;
  localparam int          FAIL_MS          = 1000;
  localparam int          LOCKOUT_MS       = 10000;
  localparam int          ENTRY_TIMEOUT_MS = 5000;

`ifdef SAFE_PW_CHANGE_EN
  localparam bit PW_CHG = 1'b1;
`else
  localparam bit PW_CHG = 1'b0;
`endif

  // State codes as listed for the feedback bus.
  localparam int M_IDLE    = 4'b0000;
  localparam int M_ENTRY   = 4'b0001;
  localparam int M_CHECK   = 4'b0010;
  localparam int M_SET     = 4'b0100;
  localparam int M_SUCCESS = 4'b0111;
  localparam int M_FAIL    = 4'b1000;
  localparam int M_LOCK    = 4'b1001;
  localparam int M_EMERG   = 4'b1010;

  logic clk_1khz = 1'b0;
  logic rst      = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  safe_lock_fsm_if bus();

  safe_lock_fsm #(
    .PW_LEN(PW_LEN), .DEFAULT_PW(DEFAULT_PW), .MAX_FAIL(MAX_FAIL),
    .SUCCESS_MS(SUCCESS_MS), .FAIL_MS(FAIL_MS), .LOCKOUT_MS(LOCKOUT_MS),
    .ENTRY_TIMEOUT_MS(ENTRY_TIMEOUT_MS)
  ) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .bus      (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st;
  int m_dig[$];
  int m_pw[$];
  int m_fail;
  int m_left;   // cycles remaining in the current timed interval

  function automatic bit code_matches();
    if (m_dig.size() != PW_LEN) return 1'b0;
    for (int i = 0; i < PW_LEN; i++) if (m_dig[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE;
    m_dig.delete();
    m_pw.delete();
    for (int i = 0; i < PW_LEN; i++) m_pw.push_back(int'((DEFAULT_PW >> (4 * (PW_LEN - 1 - i))) & 32'hF));
    m_fail = 0;
    m_left = 0;
  endtask

  task automatic go_idle_cleared();
    m_st = M_IDLE;
    m_dig.delete();
  endtask

  task automatic count_down(input bool_clear_fail);
    m_left--;
    if (m_left <= 0) begin
      m_st = M_IDLE;
      if (bool_clear_fail) m_fail = 0;
    end
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc, input logic em);
    bit dig, clr, ent;
    dig = kv && (kc <= 4'd9);
    clr = kv && (kc == 4'hA);
    ent = kv && (kc == 4'hB);
    if (em) begin
      m_st = M_EMERG;
      return;
    end
    case (m_st)
      M_EMERG: go_idle_cleared();
      M_IDLE: if (dig) begin
        m_dig.delete();
        m_dig.push_back(int'(kc));
        m_st   = M_ENTRY;
        m_left = ENTRY_TIMEOUT_MS;
      end
      M_ENTRY, M_SET: begin
        if (dig) begin
          if (m_dig.size() < PW_LEN) m_dig.push_back(int'(kc));
          m_left = ENTRY_TIMEOUT_MS;
        end else if (clr) begin
          go_idle_cleared();
        end else if (ent) begin
          if (m_st == M_ENTRY) m_st = M_CHECK;
          else begin
            if (m_dig.size() == PW_LEN) m_pw = m_dig;
            go_idle_cleared();
          end
        end else begin
          m_left--;
          if (m_left <= 0) go_idle_cleared();
        end
      end
      M_CHECK: begin
        if (code_matches()) begin
          m_st = M_SUCCESS; m_left = SUCCESS_MS; m_fail = 0;
        end else begin
          if (m_fail < 7) m_fail++;
          if (m_fail >= MAX_FAIL) begin m_st = M_LOCK; m_left = LOCKOUT_MS; end
          else begin m_st = M_FAIL; m_left = FAIL_MS; end
        end
        m_dig.delete();
      end
      M_SUCCESS: begin
        if (PW_CHG && clr) begin m_st = M_SET; m_left = ENTRY_TIMEOUT_MS; end
        else count_down(1'b0);
      end
      M_FAIL:  count_down(1'b0);
      M_LOCK:  count_down(1'b1);
      default: go_idle_cleared();
    endcase
  endtask

  always @(posedge clk_1khz or posedge rst) begin
    if (rst) model_reset();
    else     model_step(bus.key_valid, bus.key_code, bus.emergency_req);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_1khz) begin
    cyc++;
    if (cmp_en) begin
      check("cyc_state",  32'(bus.state),       32'(m_st));
      check("cyc_unlock", 32'(bus.unlock),      32'(m_st == M_SUCCESS));
      check("cyc_dcount", 32'(bus.digit_count), 32'(m_dig.size()));
      check("cyc_fcount", 32'(bus.fail_count),  32'(m_fail));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic key(input logic [3:0] k);
    @(negedge clk_1khz);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk_1khz);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  // Types the digits then '#'; returns on the first cycle after '#' is taken.
  task automatic enter_code(input logic [31:0] code, input int n);
    for (int i = n - 1; i >= 0; i--) key(4'((code >> (4 * i)) & 32'hF));
    key(4'hB);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_1khz);
  endtask

  // Called on the first cycle of a timed state: pins its code and length.
  task automatic expect_hold(input string name, input int code, input int len);
    check({name, "_first"}, 32'(bus.state), 32'(code));
    idle(len - 1);
    check({name, "_last"}, 32'(bus.state), 32'(code));
    idle(1);
    check({name, "_exit"}, 32'(bus.state), 32'(M_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.key_valid     = 1'b0;
    bus.key_code      = 4'h0;
    bus.emergency_req = 1'b0;
    #1 rst = 1'b1;
    idle(2);
    check("rst_state",  32'(bus.state), 32'h0);
    check("rst_unlock", 32'(bus.unlock), 32'h0);
    check("rst_dcount", 32'(bus.digit_count), 32'h0);
    check("rst_fcount", 32'(bus.fail_count), 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // 1: correct code
    enter_code(32'h1234, 4);
    check("t1_check", 32'(bus.state), 32'h2);
    idle(1);
    check("t1_unlock", 32'(bus.unlock), 32'h1);
    expect_hold("t1_success", M_SUCCESS, SUCCESS_MS);
    check("t1_unlock_off", 32'(bus.unlock), 32'h0);

    // 2: three wrong codes -> FAIL, FAIL, LOCKOUT
    for (int n = 1; n <= 3; n++) begin
      enter_code(32'h1235, 4);
      idle(1);
      check("t2_fcount", 32'(bus.fail_count), 32'(n));
      if (n < 3) expect_hold("t2_fail", M_FAIL, FAIL_MS);
      else       expect_hold("t2_lockout", M_LOCK, LOCKOUT_MS);
    end
    check("t2_fcount_clr", 32'(bus.fail_count), 32'h0);

    // 3: extra digit dropped; short code fails
    for (int i = 1; i <= 5; i++) key(4'(i));
    check("t3_dcount_sat", 32'(bus.digit_count), 32'h4);
    key(4'hB);
    idle(1);
    expect_hold("t3_success", M_SUCCESS, SUCCESS_MS);
    enter_code(32'h12, 2);
    idle(1);
    check("t3_short_fail", 32'(bus.state), 32'(M_FAIL));
    idle(FAIL_MS);

    // 4: entry timeout, and a key on cycle 4999 restarting it
    key(4'h1);
    check("t4_entry", 32'(bus.state), 32'(M_ENTRY));
    idle(ENTRY_TIMEOUT_MS - 1);
    check("t4_still_entry", 32'(bus.state), 32'(M_ENTRY));
    idle(1);
    check("t4_timeout", 32'(bus.state), 32'(M_IDLE));
    check("t4_dcount", 32'(bus.digit_count), 32'h0);
    key(4'h1);
    idle(ENTRY_TIMEOUT_MS - 3);
    key(4'h2);
    check("t4_restart_cnt", 32'(bus.digit_count), 32'h2);
    idle(ENTRY_TIMEOUT_MS - 1);
    check("t4_restart_hold", 32'(bus.state), 32'(M_ENTRY));
    idle(1);
    check("t4_restart_to", 32'(bus.state), 32'(M_IDLE));

    // 5: emergency mid-ENTRY and mid-LOCKOUT
    key(4'h1);
    @(negedge clk_1khz); bus.emergency_req = 1'b1;
    @(negedge clk_1khz);
    check("t5_emerg", 32'(bus.state), 32'(M_EMERG));
    check("t5_emerg_fc", 32'(bus.fail_count), 32'h1);
    bus.emergency_req = 1'b0;
    @(negedge clk_1khz);
    check("t5_release", 32'(bus.state), 32'(M_IDLE));
    check("t5_release_dc", 32'(bus.digit_count), 32'h0);
    enter_code(32'h9999, 4); idle(FAIL_MS + 1);
    enter_code(32'h9999, 4); idle(1);
    check("t5_lockout", 32'(bus.state), 32'(M_LOCK));
    idle(100);
    bus.emergency_req = 1'b1;
    @(negedge clk_1khz);
    check("t5_emerg_lock", 32'(bus.state), 32'(M_EMERG));
    idle(19);
    bus.emergency_req = 1'b0;
    @(negedge clk_1khz);
    check("t5_rel_lock", 32'(bus.state), 32'(M_IDLE));
    check("t5_rel_fc", 32'(bus.fail_count), 32'h3);
    enter_code(32'h1234, 4); idle(1);
    check("t5_success_fc", 32'(bus.fail_count), 32'h0);
    idle(SUCCESS_MS);

`ifdef SAFE_PW_CHANGE_EN
    // 6: code change
    enter_code(32'h1234, 4); idle(1);
    key(4'hA);
    check("t6_set_entry", 32'(bus.state), 32'(M_SET));
    check("t6_unlock", 32'(bus.unlock), 32'h0);
    enter_code(32'h9876, 4);
    check("t6_stored", 32'(bus.state), 32'(M_IDLE));
    enter_code(32'h9876, 4); idle(1);
    check("t6_new_ok", 32'(bus.state), 32'(M_SUCCESS));
    idle(SUCCESS_MS);
    enter_code(32'h1234, 4); idle(1);
    check("t6_old_bad", 32'(bus.state), 32'(M_FAIL));
    idle(FAIL_MS);
`endif

    // Randomized phase, checked cycle by cycle against the model.
    begin
      bit did_rst = 1'b0;
      while (cyc < 68000) begin
        int r;
        r = $urandom_range(0, 99);
        if (!did_rst && cyc > 55000) begin
          did_rst = 1'b1;
          @(negedge clk_1khz);
          #2 rst = 1'b1;
          #1 check("mid_rst_state", 32'(bus.state), 32'h0);
          check("mid_rst_fc", 32'(bus.fail_count), 32'h0);
          #1 rst = 1'b0;
        end else if (r < 55) begin
          key(4'($urandom_range(0, 15)));
          idle($urandom_range(0, 3));
        end else if (r < 72) begin
          int n;
          n = m_pw.size();
          for (int i = 0; i < n; i++) key(4'(m_pw[i]));
          key(4'hB);
        end else if (r < 80) begin
          key(4'hA);
        end else if (r < 88) begin
          @(negedge clk_1khz);
          bus.emergency_req = 1'b1;
          idle($urandom_range(1, 5));
          bus.emergency_req = 1'b0;
        end else if (r < 90) begin
          idle(ENTRY_TIMEOUT_MS + $urandom_range(0, 4));
        end else begin
          idle($urandom_range(1, 300));
        end
      end
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
